r2r_sar_multichannel: RTL and testbench

Multi-channel successive-approximation controller for the R2R ladder ADC. It drives the ladder code (`dac_code`) and the analog input mux (`channel_sel`), and waits a programmable settle time per bit before sampling a synchronised comparator. It then publishes one result per channel in round-robin order, and can optionally average several conversions per channel. It sits between the R2R ladder/comparator pins and the display/measurement logic, and supersedes the single-channel fixed-timing controller.

---
 rtl/r2r_sar_pkg.sv | 8 +
 rtl/sar_comp_sync.sv | 15 +
 rtl/r2r_sar_multichannel.sv | 147 ++++++++++++++
 tb/tb_r2r_sar_multichannel.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/r2r_sar_pkg.sv
// r2r_sar_pkg: shared FSM state type and sizing helpers for the multi-channel R2R SAR controller.
package r2r_sar_pkg;
    typedef enum logic [2:0] {IDLE, SELECT, TRIAL, DECIDE, PUBLISH} sar_state_t;
    localparam int MIN_SETTLE = 3;
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sar_comp_sync.sv
// sar_comp_sync: two-flop synchroniser for the asynchronous comparator output.
module sar_comp_sync
    import r2r_sar_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/r2r_sar_multichannel.sv
// r2r_sar_multichannel: round-robin multi-channel SAR controller for the R2R ladder ADC.
// Define R2R_SAR_AVG_EN to average 2**AVG_LOG2 conversions per channel pick.
module r2r_sar_multichannel
    import r2r_sar_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2 = 2,
    localparam int CH_W = ch_width(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [CHANNELS-1:0]        channel_mask,
    input  logic                       comparator_in,
    output logic [WIDTH-1:0]           dac_code,
    output logic [CH_W-1:0]            channel_sel,
    output logic [WIDTH-1:0]           result,
    output logic [CH_W-1:0]            result_channel,
    output logic                       result_valid,
    output logic [CHANNELS*WIDTH-1:0]  result_bank,
    output logic                       busy
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (SETTLE_CYCLES < MIN_SETTLE) begin : g_settle_check
        $error("SETTLE_CYCLES must be at least %0d", MIN_SETTLE);
    end

    sar_state_t        state;
    logic              comp_sync;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [CH_W-1:0]   last_ch, pick, cand;
    logic [WIDTH-1:0]  trial_bit, kept, final_code;
    logic              go;

    sar_comp_sync u_sync (.clk(clk), .reset(reset), .d(comparator_in), .q(comp_sync));

    // Walk downwards so the nearest set bit after last_ch wins; k = CHANNELS wraps onto last_ch itself.
    always_comb begin
        pick = last_ch;
        cand = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            cand = CH_W'((int'(last_ch) + k) % CHANNELS);
            if (channel_mask[cand]) pick = cand;
        end
    end

    assign go        = enable && (|channel_mask);
    assign trial_bit = WIDTH'(1) << idx;
    assign kept      = comp_sync ? dac_code : (dac_code & ~trial_bit);

`ifdef R2R_SAR_AVG_EN
    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam logic [AVG_LOG2:0] CONV_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
    logic [ACC_W-1:0]  acc;
    logic [AVG_LOG2:0] conv;
    assign final_code = acc[ACC_W-1:AVG_LOG2];
`else
    assign final_code = dac_code;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            dac_code       <= '0;
            channel_sel    <= '0;
            result         <= '0;
            result_channel <= '0;
            result_valid   <= 1'b0;
            result_bank    <= '0;
            cnt            <= '0;
            idx            <= '0;
            last_ch        <= CH_W'(CHANNELS - 1);
`ifdef R2R_SAR_AVG_EN
            acc            <= '0;
            conv           <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            case (state)
                SELECT: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state    <= TRIAL;
                        cnt      <= '0;
                        idx      <= IDX_W'(WIDTH - 1);
                        dac_code <= WIDTH'(1) << (WIDTH - 1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TRIAL: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 2)) begin
                        state <= DECIDE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    if (idx != '0) begin
                        state    <= TRIAL;
                        idx      <= idx - 1'b1;
                        dac_code <= kept | (trial_bit >> 1);
                    end else begin
`ifdef R2R_SAR_AVG_EN
                        acc      <= acc + ACC_W'(kept);
                        conv     <= conv + 1'b1;
                        state    <= (conv == CONV_LAST) ? PUBLISH : SELECT;
                        dac_code <= (conv == CONV_LAST) ? kept : '0;
`else
                        state    <= PUBLISH;
                        dac_code <= kept;
`endif
                    end
                end
                default: begin
                    if (state == PUBLISH) begin
                        result                                <= final_code;
                        result_channel                        <= channel_sel;
                        result_bank[channel_sel*WIDTH +: WIDTH] <= final_code;
                        result_valid                          <= 1'b1;
                    end
                    dac_code <= '0;
                    if (go) begin
                        state       <= SELECT;
                        busy        <= 1'b1;
                        channel_sel <= pick;
                        last_ch     <= pick;
                        cnt         <= '0;
`ifdef R2R_SAR_AVG_EN
                        acc         <= '0;
                        conv        <= '0;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_r2r_sar_multichannel.sv
// tb_r2r_sar_multichannel: scoreboard bench for the multi-channel R2R SAR controller.
module tb_r2r_sar_multichannel;
    localparam int WIDTH = 8;
    localparam int CHANNELS = 4;
    localparam int SETTLE = 4;
`ifdef R2R_SAR_AVG_EN
    localparam int GAP = 4 * (WIDTH + 1) * SETTLE + 1;
`else
    localparam int GAP = (WIDTH + 1) * SETTLE + 1;
`endif

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      enable = 1'b0;
    logic                      comparator_in = 1'b0;
    logic [CHANNELS-1:0]       channel_mask = '0;
    logic [WIDTH-1:0]          dac_code, result;
    logic [1:0]                channel_sel, result_channel;
    logic                      result_valid, busy;
    logic [CHANNELS*WIDTH-1:0] result_bank;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] val;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] analog[4];
    logic [7:0] prev_dac = '0;
    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         prev_cyc = -1;
    int         conv_n = 0;
    bit         gap_chk = 1'b0;
    logic       any_busy;
    logic [7:0] any_dac;

    r2r_sar_multichannel #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SETTLE_CYCLES(SETTLE), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .channel_mask(channel_mask),
        .comparator_in(comparator_in), .dac_code(dac_code), .channel_sel(channel_sel),
        .result(result), .result_channel(result_channel), .result_valid(result_valid),
        .result_bank(result_bank), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Comparator with one cycle of analog delay: input >= ladder voltage.
`ifdef R2R_SAR_AVG_EN
    always @(negedge clk) begin
        if (dac_code == 8'h80 && prev_dac != 8'h80) conv_n++;
        prev_dac = dac_code;
    end
    always @(posedge clk) comparator_in <= (((conv_n % 2) == 1) ? 8'h40 : 8'h43) >= dac_code;
`else
    always @(posedge clk) comparator_in <= analog[channel_sel] >= dac_code;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got ch %0d val %0h with empty scoreboard", result_channel, result);
            end else begin
                e = q.pop_front();
                chk("result", result, e.val);
                chk("result_channel", result_channel, e.ch);
                if (gap_chk && prev_cyc >= 0) chk("valid_gap", cycle - prev_cyc, GAP);
                prev_cyc = cycle;
            end
        end
    end

    task automatic push(input logic [1:0] ch, input logic [7:0] val);
        q.push_back('{ch: ch, val: val});
    endtask

    task automatic wait_q(input int n, input string name);
        for (int i = 0; i < 3000 && q.size() > n; i++) @(negedge clk);
        chk(name, q.size(), n);
    endtask

    task automatic wait_valid(input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!result_valid && i < 3000);
        chk(name, result_valid, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        prev_cyc = -1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dac"}, dac_code, 0);
        chk({tag, "_sel"}, channel_sel, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_rch"}, result_channel, 0);
        chk({tag, "_rvalid"}, result_valid, 0);
        chk({tag, "_bank"}, result_bank, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        analog = '{8'hA5, 8'h00, 8'hFF, 8'h80};
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clk);
`ifdef R2R_SAR_AVG_EN
        channel_mask = 4'b0001;
        gap_chk = 1'b1;
        push(2'd0, 8'h41);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_q(0, "avg_drain");
        @(negedge clk);
        chk("avg_idle", busy, 0);
        chk("avg_bank", result_bank, 32'h0000_0041);
`else
        // Full round-robin scan, two extra results past the first lap.
        channel_mask = 4'b1111;
        gap_chk = 1'b1;
        push(2'd0, 8'hA5); push(2'd1, 8'h00); push(2'd2, 8'hFF);
        push(2'd3, 8'h80); push(2'd0, 8'hA5); push(2'd1, 8'h00);
        enable = 1'b1;
        wait_q(1, "scan_five");
        enable = 1'b0;
        wait_q(0, "scan_drain");
        @(negedge clk);
        chk("scan_idle", busy, 0);
        chk("scan_bank", result_bank, 32'h80FF_00A5);

        do_reset();
        channel_mask = 4'b0101;
        push(2'd0, 8'hA5); push(2'd2, 8'hFF); push(2'd0, 8'hA5); push(2'd2, 8'hFF);
        enable = 1'b1;
        wait_q(1, "alt_three");
        enable = 1'b0;
        wait_q(0, "alt_drain");
        @(negedge clk);
        chk("alt_bank", result_bank, 32'h00FF_00A5);

        do_reset();
        channel_mask = 4'b0000;
        enable = 1'b1;
        any_busy = 1'b0;
        any_dac = '0;
        repeat (40) begin
            @(negedge clk);
            any_busy |= busy;
            any_dac |= dac_code;
        end
        chk("mask0_busy", any_busy, 0);
        chk("mask0_dac", any_dac, 0);
        enable = 1'b0;

        // Drop enable during the third trial (bit 5) of channel 1.
        do_reset();
        analog[1] = 8'h3C;
        channel_mask = 4'b1111;
        push(2'd0, 8'hA5); push(2'd1, 8'h3C);
        enable = 1'b1;
        wait_valid("drop_first_valid");
        repeat (13) @(negedge clk);
        chk("third_trial_dac", dac_code, 8'h20);
        enable = 1'b0;
        wait_valid("drop_ch1_valid");
        chk("drop_busy_low", busy, 0);
        any_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_busy |= busy;
        end
        chk("drop_no_select", any_busy, 0);
        chk("drop_queue_empty", q.size(), 0);

        // Last picked channel is 1, so this scan starts on channel 2; reset lands in its first DECIDE.
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #2;
        chk("pre_reset_dac", dac_code, 8'h80);
        chk("pre_reset_sel", channel_sel, 2);
        reset = 1'b0;
        #1;
        chk_zero("decide_reset");
        channel_mask = 4'b1110;
        push(2'd1, 8'h3C);
        @(negedge clk);
        reset = 1'b1;
        prev_cyc = -1;
        repeat (3) @(negedge clk);
        chk("post_reset_sel", channel_sel, 1);
        enable = 1'b0;
        wait_q(0, "post_reset_drain");
        @(negedge clk);
        chk("post_reset_idle", busy, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
